interrupt_drain_sequencer: RTL and testbench
============================================

INTERRUPT_DRAIN_SEQUENCER -- requirements
Module: interrupt_drain_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_IRQ_SRC, default 4, giving the number of interrupt request lines.
REQ-002 The block SHALL have parameter DRAIN_TIMEOUT, default 64, giving the maximum number of DRAIN cycles before abandon.
REQ-003 The block SHALL have parameter HOLDOFF_CYCLES, default 2, giving the number of post-take cycles during which new requests are ignored.
REQ-004 clk  in  1  the single clock.
REQ-005 rst  in  1  reset, synchronous and active-low.
REQ-006 irqReq  in  NUM_IRQ_SRC  level-sensitive requests; index 0 has the highest priority.
REQ-007 irqEnable  in  1  global interrupt enable.
REQ-008 wholePipelineEmpty  in  1  no live instruction in any stage or the active list.
REQ-009 cmStageFlushUpper  in  1  commit-stage flush in progress.
REQ-010 irqAck  in  1  the recovery manager accepts the take and redirects the PC.
REQ-011 npStageSendBubbleLowerForInterrupt  out  1  fetch bubble request to the controller.
REQ-012 irqTakeValid  out  1  take request to the recovery manager.
REQ-013 irqCause  out  $clog2(NUM_IRQ_SRC)  latched source index.
REQ-014 drainTimeout  out  1  sticky error flag.
REQ-015 busy  out  1  the FSM is not in IDLE.

Function
REQ-016 The FSM SHALL have the states IDLE, DRAIN, TAKE and HOLDOFF, and every output SHALL be a registered function of the state.
REQ-017 In IDLE with irqEnable=1 and |irqReq, the block SHALL latch the lowest set index into irqCause and enter DRAIN on the next edge.
REQ-018 npStageSendBubbleLowerForInterrupt SHALL be 1 in DRAIN and TAKE and 0 in IDLE and HOLDOFF, so bubbling starts the cycle after detection.
REQ-019 In DRAIN, the block SHALL return to IDLE when irqEnable=0 or irqReq[irqCause]=0 (abort), and abort SHALL take priority over every other transition.
REQ-020 In DRAIN without abort, wholePipelineEmpty=1 and cmStageFlushUpper=0 SHALL move the FSM to TAKE.
REQ-021 A flush SHALL block the take only in the cycle it is asserted.
REQ-022 The DRAIN counter SHALL be $clog2(DRAIN_TIMEOUT)+1 bits, clear on DRAIN entry, increment each DRAIN cycle and saturate.
REQ-023 When the counter reaches DRAIN_TIMEOUT-1 with no take and no abort, the block SHALL set drainTimeout and go to IDLE.
REQ-024 If the take condition and the timeout condition occur in the same cycle, the take SHALL win.
REQ-025 In TAKE, irqTakeValid SHALL be 1 and irqCause SHALL be stable until irqAck=1, after which the FSM SHALL enter HOLDOFF; a request that deasserts during TAKE SHALL NOT cancel it.
REQ-026 irqAck outside TAKE SHALL be ignored.
REQ-027 HOLDOFF SHALL last exactly HOLDOFF_CYCLES cycles using a down-counter, then return to IDLE, and irqReq SHALL be ignored throughout.
REQ-028 irqCause SHALL change only on the IDLE->DRAIN transition.
REQ-029 The latency from a request in IDLE to irqTakeValid SHALL be at least 2 cycles (empty pipeline: IDLE->DRAIN->TAKE).

Reset
REQ-030 When rst=0 at a clock edge, the block SHALL enter IDLE, clear both counters, and drive every output to 0 (irqCause=0, drainTimeout=0); this applies from any state.
REQ-031 A reset during TAKE SHALL drop irqTakeValid on the following cycle, and a pending irqAck SHALL be discarded.

Configuration
REQ-032 With RSD_IRQ_DRAIN_TIMEOUT_EN defined, the DRAIN counter, the timeout transition and drainTimeout SHALL be implemented.
REQ-033 Without RSD_IRQ_DRAIN_TIMEOUT_EN, the counter SHALL be omitted, DRAIN SHALL wait indefinitely (abort still applies), and drainTimeout SHALL be tied to 0.

Structure
REQ-034 The IrqDrainState enum, the IrqCausePath typedef and the default parameter constants SHALL live in PipelineTypes.
REQ-035 The block SHALL contain one sub-module, irq_priority_encoder, which SHALL be combinational, NUM_IRQ_SRC->index plus valid, lowest index wins.

Verification
REQ-036 The bench SHALL cover: irqReq=4'b0110, irqEnable=1, pipeline empty -> DRAIN at t+1, TAKE at t+2, irqCause=1; irqAck at t+4 -> HOLDOFF t+5..t+6, IDLE t+7.
REQ-037 The bench SHALL cover: wholePipelineEmpty=0 for 10 DRAIN cycles then 1 with cmStageFlushUpper=1 for 1 cycle -> TAKE one cycle later than the empty edge, and bubble held high throughout.
REQ-038 The bench SHALL cover: irqReq[2] dropped in the 3rd DRAIN cycle, in the same cycle as wholePipelineEmpty=1 -> IDLE, no irqTakeValid, bubble low next cycle.
REQ-039 The bench SHALL cover, with the macro defined: pipeline never empty -> drainTimeout=1 after 64 DRAIN cycles, FSM in IDLE, re-entry to DRAIN the next cycle; without the macro -> FSM stays in DRAIN for 200 cycles with drainTimeout=0.
REQ-040 The bench SHALL cover: rst=0 asserted during TAKE with irqAck=1 in the same cycle -> all outputs 0 next cycle, FSM in IDLE, no HOLDOFF.
REQ-041 The bench SHALL cover: irqReq held during HOLDOFF -> no new DRAIN until IDLE, then DRAIN the following cycle.

Source files
------------

// File: rtl/interrupt_drain_sequencer_pkg.sv
// Shared types and default constants for the interrupt drain sequencer.
// The drain timeout logic is enabled by defining RSD_IRQ_DRAIN_TIMEOUT_EN.
package PipelineTypes;

    localparam int DEFAULT_NUM_IRQ_SRC    = 4;
    localparam int DEFAULT_DRAIN_TIMEOUT  = 64;
    localparam int DEFAULT_HOLDOFF_CYCLES = 2;

    // Width of an index into n items, never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEFAULT_IRQ_CAUSE_W = idx_width(DEFAULT_NUM_IRQ_SRC);

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_DRAIN   = 2'd1,
        IRQ_TAKE    = 2'd2,
        IRQ_HOLDOFF = 2'd3
    } IrqDrainState;

    typedef logic [DEFAULT_IRQ_CAUSE_W-1:0] IrqCausePath;

endpackage

// File: rtl/interrupt_drain_sequencer_prio.sv
// Combinational fixed-priority encoder: lowest set request index wins.
module irq_priority_encoder
    import PipelineTypes::*;
#(
    parameter int NUM_IRQ_SRC = DEFAULT_NUM_IRQ_SRC,
    parameter int IDX_W       = idx_width(NUM_IRQ_SRC)
) (
    input  logic [NUM_IRQ_SRC-1:0] i_req,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_valid
);

    // Scan from the highest index down so the lowest set bit is written last.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = NUM_IRQ_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end else begin
                o_idx   = o_idx;
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/interrupt_drain_sequencer.sv
// Drains the pipeline before handing an interrupt to the recovery manager.
// Define RSD_IRQ_DRAIN_TIMEOUT_EN to build the DRAIN watchdog and drainTimeout flag.
module interrupt_drain_sequencer
    import PipelineTypes::*;
#(
    parameter int NUM_IRQ_SRC    = DEFAULT_NUM_IRQ_SRC,
    parameter int DRAIN_TIMEOUT  = DEFAULT_DRAIN_TIMEOUT,
    parameter int HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_IRQ_SRC-1:0]             irqReq,
    input  logic                               irqEnable,
    input  logic                               wholePipelineEmpty,
    input  logic                               cmStageFlushUpper,
    input  logic                               irqAck,
    output logic                               npStageSendBubbleLowerForInterrupt,
    output logic                               irqTakeValid,
    output logic [idx_width(NUM_IRQ_SRC)-1:0]  irqCause,
    output logic                               drainTimeout,
    output logic                               busy
);

    localparam int CAUSE_W = idx_width(NUM_IRQ_SRC);
    localparam int HOLD_W  = idx_width(HOLDOFF_CYCLES);

    IrqDrainState       r_state;
    logic [CAUSE_W-1:0] r_cause;
    logic [HOLD_W-1:0]  r_hold_cnt;
    logic               r_bubble;
    logic               r_take;
    logic               r_busy;

    logic [CAUSE_W-1:0] w_src_idx;
    logic               w_src_valid;
    logic               w_abort;
    logic               w_take_ok;

    irq_priority_encoder #(
        .NUM_IRQ_SRC (NUM_IRQ_SRC),
        .IDX_W       (CAUSE_W)
    ) u_prio (
        .i_req   (irqReq),
        .o_idx   (w_src_idx),
        .o_valid (w_src_valid)
    );

    assign w_abort   = !irqEnable || !irqReq[r_cause];
    assign w_take_ok = wholePipelineEmpty && !cmStageFlushUpper;

`ifdef RSD_IRQ_DRAIN_TIMEOUT_EN
    localparam int                CNT_W        = $clog2(DRAIN_TIMEOUT) + 1;
    localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(DRAIN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX      = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_drain_cnt;
    logic             r_timeout;

    assign drainTimeout = r_timeout;
`else
    assign drainTimeout = 1'b0;
`endif

    // State machine; outputs are registered alongside the state they describe.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IRQ_IDLE;
            r_cause    <= '0;
            r_hold_cnt <= '0;
            r_bubble   <= 1'b0;
            r_take     <= 1'b0;
            r_busy     <= 1'b0;
`ifdef RSD_IRQ_DRAIN_TIMEOUT_EN
            r_drain_cnt <= '0;
            r_timeout   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IRQ_IDLE: begin
                    if (irqEnable && w_src_valid) begin
                        r_state  <= IRQ_DRAIN;
                        r_cause  <= w_src_idx;
                        r_bubble <= 1'b1;
                        r_busy   <= 1'b1;
`ifdef RSD_IRQ_DRAIN_TIMEOUT_EN
                        r_drain_cnt <= '0;
`endif
                    end
                end
                IRQ_DRAIN: begin
                    if (w_abort) begin
                        r_state  <= IRQ_IDLE;
                        r_bubble <= 1'b0;
                        r_busy   <= 1'b0;
                    end else if (w_take_ok) begin
                        r_state <= IRQ_TAKE;
                        r_take  <= 1'b1;
                    end
`ifdef RSD_IRQ_DRAIN_TIMEOUT_EN
                    else if (r_drain_cnt == TIMEOUT_LAST) begin
                        r_state   <= IRQ_IDLE;
                        r_bubble  <= 1'b0;
                        r_busy    <= 1'b0;
                        r_timeout <= 1'b1;
                    end else if (r_drain_cnt != CNT_MAX) begin
                        r_drain_cnt <= r_drain_cnt + 1'b1;
                    end
`endif
                end
                IRQ_TAKE: begin
                    // Once here the take is committed; only the ack moves us on.
                    if (irqAck) begin
                        r_take   <= 1'b0;
                        r_bubble <= 1'b0;
                        if (HOLDOFF_CYCLES == 0) begin
                            r_state <= IRQ_IDLE;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state    <= IRQ_HOLDOFF;
                            r_hold_cnt <= HOLD_W'(HOLDOFF_CYCLES - 1);
                        end
                    end
                end
                IRQ_HOLDOFF: begin
                    if (r_hold_cnt == '0) begin
                        r_state <= IRQ_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 1'b1;
                    end
                end
                default: begin
                    r_state  <= IRQ_IDLE;
                    r_bubble <= 1'b0;
                    r_take   <= 1'b0;
                    r_busy   <= 1'b0;
                end
            endcase
        end
    end

    assign npStageSendBubbleLowerForInterrupt = r_bubble;
    assign irqTakeValid = r_take;
    assign irqCause     = r_cause;
    assign busy         = r_busy;

endmodule

// File: tb/tb_interrupt_drain_sequencer.sv
// Directed bench for interrupt_drain_sequencer; follows RSD_IRQ_DRAIN_TIMEOUT_EN when defined.
module tb_interrupt_drain_sequencer;
    import PipelineTypes::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irqReq;
    logic        irqEnable;
    logic        wholePipelineEmpty;
    logic        cmStageFlushUpper;
    logic        irqAck;
    logic        bubble;
    logic        irqTakeValid;
    IrqCausePath irqCause;
    logic        drainTimeout;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    logic tmo_seen;

    interrupt_drain_sequencer dut (
        .clk                                (clk),
        .rst                                (rst),
        .irqReq                             (irqReq),
        .irqEnable                          (irqEnable),
        .wholePipelineEmpty                 (wholePipelineEmpty),
        .cmStageFlushUpper                  (cmStageFlushUpper),
        .irqAck                             (irqAck),
        .npStageSendBubbleLowerForInterrupt (bubble),
        .irqTakeValid                       (irqTakeValid),
        .irqCause                           (irqCause),
        .drainTimeout                       (drainTimeout),
        .busy                               (busy)
    );

    always #5 clk = ~clk;

    // Advance one clock edge and settle before looking at outputs.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected output bundle: {bubble, take, busy, timeout, cause}.
    function automatic logic [5:0] ev(input logic b, input logic t, input logic bz,
                                      input logic tmo, input logic [1:0] c);
        return {b, t, bz, tmo, c};
    endfunction

    task automatic chk(input string tag, input logic [5:0] exp);
        logic [5:0] obs;
        obs = {bubble, irqTakeValid, busy, drainTimeout, irqCause};
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; irqReq = 4'b0000; irqEnable = 1'b0;
        wholePipelineEmpty = 1'b0; cmStageFlushUpper = 1'b0; irqAck = 1'b0;
        tmo_seen = 1'b0;
        step(); step();
        chk("reset_state", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        rst = 1'b1;

        // Basic take with empty pipeline, then holdoff with request still held.
        irqReq = 4'b0110; irqEnable = 1'b1; wholePipelineEmpty = 1'b1;
        step(); chk("basic_drain_t1", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
        step(); chk("basic_take_t2",  ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        step(); chk("basic_take_t3",  ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        step(); chk("basic_take_t4",  ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        irqAck = 1'b1;
        step(); chk("holdoff_t5", ev(1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
        irqAck = 1'b0;
        step(); chk("holdoff_t6", ev(1'b0, 1'b0, 1'b1, 1'b0, 2'd1));
        step(); chk("idle_t7",    ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        step(); chk("redrain_t8", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd1));
        step(); chk("retake_t9",  ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        irqReq = 4'b0000;
        step(); chk("take_survives_req_drop", ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd1));
        irqAck = 1'b1;
        step(); irqAck = 1'b0;
        step(); step();
        chk("idle_after_second_take", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        irqAck = 1'b1;
        step(); chk("ack_ignored_in_idle", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd1));
        irqAck = 1'b0;

        // Long drain, then a one-cycle flush delays the take by one cycle.
        irqReq = 4'b1000; wholePipelineEmpty = 1'b0;
        step(); chk("long_drain_entry", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        for (int i = 0; i < 9; i++) begin
            step(); chk("long_drain_hold", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        end
        wholePipelineEmpty = 1'b1; cmStageFlushUpper = 1'b1;
        step(); chk("flush_blocks_take", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd3));
        cmStageFlushUpper = 1'b0;
        step(); chk("take_after_flush", ev(1'b1, 1'b1, 1'b1, 1'b0, 2'd3));
        irqReq = 4'b0000; irqAck = 1'b1;
        step(); irqAck = 1'b0;
        step(); step();
        chk("idle_after_flush_take", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd3));

        // Request drop in 3rd drain cycle beats a simultaneous empty pipeline.
        irqReq = 4'b0100; wholePipelineEmpty = 1'b0;
        step(); step(); step();
        chk("abort_third_drain", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd2));
        irqReq = 4'b0000; wholePipelineEmpty = 1'b1;
        step(); chk("abort_to_idle", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd2));
        wholePipelineEmpty = 1'b0;

        // Global enable drop aborts the drain.
        irqReq = 4'b0001;
        step(); chk("enable_drain", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        irqEnable = 1'b0;
        step(); chk("enable_abort", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        irqEnable = 1'b1;

        // Pipeline never drains.
        step(); chk("tmo_drain_entry", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
`ifdef RSD_IRQ_DRAIN_TIMEOUT_EN
        for (int i = 1; i < 64; i++) begin
            step(); chk("tmo_drain_hold", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        end
        step(); chk("tmo_to_idle", ev(1'b0, 1'b0, 1'b0, 1'b1, 2'd0));
        step(); chk("tmo_reenter", ev(1'b1, 1'b0, 1'b1, 1'b1, 2'd0));
        tmo_seen = 1'b1;
`else
        for (int i = 1; i < 200; i++) begin
            step(); chk("no_tmo_drain_hold", ev(1'b1, 1'b0, 1'b1, 1'b0, 2'd0));
        end
`endif
        irqReq = 4'b0000;
        step(); chk("tmo_abort_sticky", ev(1'b0, 1'b0, 1'b0, tmo_seen, 2'd0));

        // Reset during TAKE with a simultaneous ack.
        irqReq = 4'b0010; wholePipelineEmpty = 1'b1;
        step(); step();
        chk("rst_take_reached", ev(1'b1, 1'b1, 1'b1, tmo_seen, 2'd1));
        rst = 1'b0; irqAck = 1'b1;
        step(); chk("rst_in_take", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));
        rst = 1'b1; irqAck = 1'b0; irqReq = 4'b0000;
        step(); chk("rst_no_holdoff", ev(1'b0, 1'b0, 1'b0, 1'b0, 2'd0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
